// File: rtl/adam_periph_uart_tx_arb.sv
// Purpose: round-robin arbiter that locks one requester's whole message onto a single UART transmit stream, with a pause/quiesce handshake.
// Latency: a grant is registered one cycle after valid is seen in IDLE; once locked, the datapath from owner to UART is combinational.
// Backpressure: data_ready is passed straight to the owner's req_ready; non-owners always see req_ready=0, and a message is never split.
module adam_periph_uart_tx_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pause_req,
  output logic                               pause_ack,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [DATA_WIDTH-1:0]              data,
  output logic                               data_valid,
  input  logic                               data_ready,
  output logic [IDW-1:0]                     grant_id,
  output logic                               busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] rr_ptr;

  logic           locked;
  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic           last_xfer;
  logic [IDW-1:0] owner_next_ptr;

  assign locked = (state == ST_LOCKED);

  // Round-robin search starting at rr_ptr; walking the offsets downwards lets the smallest offset win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // Message end: the owner's last word is accepted by the transmitter.
  assign last_xfer = locked && req_valid[owner] && req_last[owner] && data_ready;

  // Pointer moves just past the finishing owner, wrapping at NUM_REQ-1 (stays 0 for a single requester).
  assign owner_next_ptr = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Owner-to-UART mux; everything is zero outside LOCKED so reset clears outputs immediately.
  always_comb begin
    data       = '0;
    data_valid = 1'b0;
    req_ready  = '0;
    if (locked) begin
      data             = req_data[owner];
      data_valid       = req_valid[owner];
      req_ready[owner] = data_ready;
    end
  end

  assign busy     = locked;
  assign grant_id = locked ? owner : '0;

  // Arbitration FSM: grant in IDLE, hold the lock until the last word, quiesce on pause only between messages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      pause_ack <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pause_req) begin
            state     <= ST_PAUSED;
            pause_ack <= 1'b1;
          end else if (pick_vld) begin
            state <= ST_LOCKED;
            owner <= pick_idx;
          end
        end
        ST_LOCKED: begin
          if (last_xfer) begin
            rr_ptr <= owner_next_ptr;
            if (pause_req) begin
              state     <= ST_PAUSED;
              pause_ack <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause_req) begin
            state     <= ST_IDLE;
            pause_ack <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          pause_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adam_periph_uart_tx_arb.sv
// Directed bench for the UART transmit arbiter: grant latency, round-robin order, backpressure, pause and reset.
// Requesters are modelled as per-port word counters; every accepted word is logged with the grant id seen with it.
// Outputs are sampled mid-cycle, inputs are driven just after the rising edge.
module tb_adam_periph_uart_tx_arb;

  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic                   clk;
  logic                   rst;
  logic                   pause_req;
  logic                   pause_ack;
  logic [N-1:0][DW-1:0]   req_data;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_last;
  logic [N-1:0]           req_ready;
  logic [DW-1:0]          data;
  logic                   data_valid;
  logic                   data_ready;
  logic [IDW-1:0]         grant_id;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  // Requester model
  int            len    [N];
  int            idx    [N];
  logic [DW-1:0] base   [N];
  bit            active [N];
  bit            cont;

  logic [DW-1:0]  got_dat[$];
  logic [IDW-1:0] got_id [$];

  adam_periph_uart_tx_arb #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .pause_req  (pause_req),
    .pause_ack  (pause_ack),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      req_valid[p] = active[p];
      req_data[p]  = base[p] + DW'(idx[p]);
      req_last[p]  = (idx[p] == len[p] - 1);
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < N; p++) begin
      len[p]    = 1;
      idx[p]    = 0;
      base[p]   = '0;
      active[p] = 1'b0;
    end
    cont = 1'b0;
    got_dat.delete();
    got_id.delete();
  endtask

  // One clock: log the accepted word, cross the edge, advance the requesters that transferred.
  task automatic tick();
    logic [N-1:0] xf;
    drive();
    #1;
    xf = req_valid & req_ready;
    if (data_valid && data_ready) begin
      got_dat.push_back(data);
      got_id.push_back(grant_id);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (xf[p]) begin
        if (idx[p] == len[p] - 1) begin
          idx[p] = 0;
          if (!cont) active[p] = 1'b0;
        end else begin
          idx[p] = idx[p] + 1;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    pause_req  = 1'b0;
    data_ready = 1'b1;
    drive();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    for (int p = 0; p < N; p++) begin
      active[p] = 1'b1;
      base[p]   = 32'h0000_0010 * p;
    end
    pause_req  = 1'b0;
    data_ready = 1'b1;
    drive();
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (pause_ack !== 1'b0) begin errors++; $display("FAIL reset_pause_ack: got %b expected 0", pause_ack); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
    rst = 1'b0;
    clear_model();
    drive();
    #1;
  endtask

  task automatic test_single();
    clear_model();
    active[2] = 1'b1; len[2] = 3; base[2] = 32'h41;
    data_ready = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", grant_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    checks++; if (data !== 32'h41 || data_valid !== 1'b1) begin errors++; $display("FAIL single_first_word: got %h/%b expected 41/1", data, data_valid); end
    tick(); tick(); tick();
    checks++; if (got_dat.size() != 3) begin errors++; $display("FAIL single_count: got %0d expected 3", got_dat.size()); end
    for (int k = 0; k < 3 && k < got_dat.size(); k++) begin
      checks++; if (got_dat[k] !== 32'h41 + k) begin errors++; $display("FAIL single_word%0d: got %h expected %h", k, got_dat[k], 32'h41 + k); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    // rr_ptr should now be 3: with ports 0 and 3 valid, port 3 wins
    active[0] = 1'b1; len[0] = 1; base[0] = 32'h50;
    active[3] = 1'b1; len[3] = 1; base[3] = 32'h53;
    tick();
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL single_rr_ptr3: got %0d expected 3", grant_id); end
    for (int c = 0; c < 10 && got_dat.size() < 5; c++) tick();
    checks++; if (got_dat.size() != 5) begin errors++; $display("FAIL single_tail_count: got %0d expected 5", got_dat.size()); end
    else begin
      checks++; if (got_dat[3] !== 32'h53 || got_dat[4] !== 32'h50) begin errors++; $display("FAIL single_tail_order: got %h,%h expected 53,50", got_dat[3], got_dat[4]); end
    end
  endtask

  task automatic test_round_robin();
    logic [IDW-1:0] exp_id [10];
    exp_id = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    do_reset();
    cont = 1'b1;
    for (int p = 0; p < N; p++) begin
      active[p] = 1'b1; len[p] = 2; base[p] = 32'h100 * p;
    end
    for (int c = 0; c < 40 && got_dat.size() < 10; c++) tick();
    checks++; if (got_dat.size() < 10) begin errors++; $display("FAIL rr_count: got %0d expected 10", got_dat.size()); end
    else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (got_id[k] !== exp_id[k] || got_dat[k] !== 32'h100 * exp_id[k] + (k % 2)) begin
          errors++;
          $display("FAIL rr_word%0d: got id %0d data %h expected id %0d data %h", k, got_id[k], got_dat[k], exp_id[k], 32'h100 * exp_id[k] + (k % 2));
        end
      end
    end
    cont = 1'b0;
  endtask

  task automatic test_backpressure();
    logic          dr_pat [5];
    logic [DW-1:0] held;
    dr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    active[1] = 1'b1; len[1] = 3; base[1] = 32'hA0;
    tick();
    for (int c = 0; c < 5; c++) begin
      data_ready = dr_pat[c];
      #1;
      checks++; if (req_ready[1] !== dr_pat[c] || data_valid !== 1'b1) begin errors++; $display("FAIL bp_ready%0d: got rdy %b vld %b expected rdy %b vld 1", c, req_ready[1], data_valid, dr_pat[c]); end
      held = data;
      tick();
      if (!dr_pat[c]) begin
        checks++; if (data !== held) begin errors++; $display("FAIL bp_hold%0d: got %h expected %h", c, data, held); end
      end
    end
    checks++; if (got_dat.size() != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got_dat.size()); end
    else begin
      checks++; if (got_dat[0] !== 32'hA0 || got_dat[1] !== 32'hA1 || got_dat[2] !== 32'hA2) begin errors++; $display("FAIL bp_words: got %h,%h,%h expected a0,a1,a2", got_dat[0], got_dat[1], got_dat[2]); end
    end
    data_ready = 1'b1;
  endtask

  task automatic test_pause_mid();
    do_reset();
    active[0] = 1'b1; len[0] = 4; base[0] = 32'hC0;
    tick();
    tick();
    pause_req = 1'b1;
    tick();
    checks++; if (pause_ack !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pmid_holdoff: got ack %b busy %b expected 0 1", pause_ack, busy); end
    tick(); tick();
    checks++; if (got_dat.size() != 4) begin errors++; $display("FAIL pmid_count: got %0d expected 4", got_dat.size()); end
    else begin
      checks++; if (got_dat[0] !== 32'hC0 || got_dat[3] !== 32'hC3) begin errors++; $display("FAIL pmid_words: got %h..%h expected c0..c3", got_dat[0], got_dat[3]); end
    end
    checks++; if (pause_ack !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL pmid_ack: got ack %b busy %b expected 1 0", pause_ack, busy); end
    active[2] = 1'b1; len[2] = 1; base[2] = 32'hD0;
    tick(); tick(); tick();
    checks++; if (got_dat.size() != 4 || req_ready !== 4'b0000 || data_valid !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL pmid_ignored: got count %0d rdy %b vld %b gid %0d expected 4 0000 0 0", got_dat.size(), req_ready, data_valid, grant_id);
    end
    pause_req = 1'b0;
    tick();
    checks++; if (pause_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pmid_release: got ack %b busy %b expected 0 0", pause_ack, busy); end
    tick();
    checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL pmid_resume: got gid %0d busy %b expected 2 1", grant_id, busy); end
    tick();
    checks++; if (got_dat.size() != 5 || got_dat[got_dat.size()-1] !== 32'hD0) begin errors++; $display("FAIL pmid_resume_word: got count %0d expected 5 with d0", got_dat.size()); end
  endtask

  task automatic test_pause_idle();
    do_reset();
    pause_req = 1'b1;
    active[1] = 1'b1; len[1] = 1; base[1] = 32'hB0;
    tick();
    checks++; if (pause_ack !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL pidle_ack: got ack %b busy %b expected 1 0", pause_ack, busy); end
    checks++; if (req_ready !== 4'b0000 || data_valid !== 1'b0) begin errors++; $display("FAIL pidle_nogrant: got rdy %b vld %b expected 0000 0", req_ready, data_valid); end
    pause_req = 1'b0;
    tick();
    checks++; if (pause_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pidle_release: got ack %b busy %b expected 0 0", pause_ack, busy); end
    tick();
    checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL pidle_grant: got gid %0d busy %b expected 1 1", grant_id, busy); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    active[0] = 1'b1; len[0] = 4; base[0] = 32'hE0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || data_valid !== 1'b0 || req_ready !== 4'b0000 || data !== 32'h0 || pause_ack !== 1'b0) begin
      errors++; $display("FAIL rmid_async: got busy %b gid %0d vld %b rdy %b data %h ack %b expected all 0", busy, grant_id, data_valid, req_ready, data, pause_ack);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_model();
    active[3] = 1'b1; len[3] = 1; base[3] = 32'hF3;
    active[1] = 1'b1; len[1] = 1; base[1] = 32'hF1;
    tick();
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL rmid_regrant: got %0d expected 1", grant_id); end
    for (int c = 0; c < 10 && got_dat.size() < 2; c++) tick();
    checks++; if (got_dat.size() != 2) begin errors++; $display("FAIL rmid_count: got %0d expected 2", got_dat.size()); end
    else begin
      checks++; if (got_dat[0] !== 32'hF1 || got_dat[1] !== 32'hF3) begin errors++; $display("FAIL rmid_order: got %h,%h expected f1,f3", got_dat[0], got_dat[1]); end
    end
  endtask

  initial begin
    rst        = 1'b1;
    pause_req  = 1'b0;
    data_ready = 1'b0;
    req_data   = '0;
    req_valid  = '0;
    req_last   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pause_mid();
    test_pause_idle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adam_periph_uart_tx_arb.md
ADAM_PERIPH_UART_TX_ARB -- requirements
Module: adam_periph_uart_tx_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every data word.
REQ-002 Parameter NUM_REQ, default 4: number of requester ports, legal range 1..16.
REQ-003 Derived width IDW = max(1, $clog2(NUM_REQ)): width of owner and pointer fields.
REQ-004 Reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 pause_req  input  1  request to quiesce the block.
REQ-008 pause_ack  output  1  block quiesced; no transfers while high.
REQ-009 req_data  input  NUM_REQ x DATA_WIDTH  per-requester data word.
REQ-010 req_valid  input  NUM_REQ  per-requester word valid.
REQ-011 req_last  input  NUM_REQ  marks the final word of a requester's message.
REQ-012 req_ready  output  NUM_REQ  per-requester word accepted.
REQ-013 data  output  DATA_WIDTH  word to the UART transmitter.
REQ-014 data_valid  output  1  word valid to the UART transmitter.
REQ-015 data_ready  input  1  UART transmitter accepts the word.
REQ-016 grant_id  output  IDW  index of the current owner; 0 when none.
REQ-017 busy  output  1  high while a message is locked to an owner.

Function
REQ-018 States: IDLE, LOCKED, PAUSED; state, owner, rr_ptr and pause_ack are registers.
REQ-019 Transfer on a port occurs in any cycle with valid and ready both high on that port.
REQ-020 IDLE, pause_req=1: next state PAUSED, regardless of req_valid.
REQ-021 IDLE, pause_req=0, some req_valid=1: owner = first requester with valid, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ; next state LOCKED.
REQ-022 IDLE, nothing valid, pause_req=0: remain IDLE.
REQ-023 Grant latency: one cycle; the earliest transfer is the cycle after req_valid is first sampled in IDLE.
REQ-024 LOCKED datapath is combinational: data=req_data[owner], data_valid=req_valid[owner], req_ready[owner]=data_ready.
REQ-025 req_ready of non-owners is 0 at all times; in IDLE and PAUSED, data_valid=0, data=0, and all req_ready=0.
REQ-026 LOCKED: the owner keeps the grant until a transfer with req_last[owner]=1; owner valid deasserting mid-message does not release it.
REQ-027 On the last-word transfer: rr_ptr = (owner+1) modulo NUM_REQ, wrapping NUM_REQ-1 to 0.
REQ-028 On the last-word transfer: next state PAUSED if pause_req=1, else IDLE.
REQ-029 pause_req asserted during LOCKED is held off until the message ends; no word is dropped or split.
REQ-030 PAUSED: pause_ack=1 (registered, asserted the cycle the state is entered); no grants.
REQ-031 PAUSED, pause_req=0: next state IDLE, pause_ack=0 in that same next cycle.
REQ-032 busy = (state==LOCKED); grant_id = owner in LOCKED, else 0.
REQ-033 NUM_REQ=1: rr_ptr is constant 0; all other behaviour is unchanged.
REQ-034 data and data_valid depend only on registered state and owner inputs; there is no combinational path from data_ready to data_valid.

Reset
REQ-035 rst=1 forces state=IDLE, owner=0, rr_ptr=0, pause_ack=0, busy=0, grant_id=0, data_valid=0, all req_ready=0, immediately and asynchronously.
REQ-036 rst asserted mid-message abandons the lock; after release, arbitration restarts at requester 0 and the requester must resend from its first word.

Verification
REQ-037 Single requester: port 2 sends 3 words 0x41,0x42,0x43 (last on 0x43), data_ready=1 -> grant_id=2 one cycle after valid; data carries 0x41,0x42,0x43 on consecutive cycles; busy drops after 0x43; rr_ptr=3.
REQ-038 Round-robin: all 4 ports continuously valid with 2-word messages -> grant order 0,1,2,3,0; no interleaving of words within a message.
REQ-039 Backpressure: data_ready toggles 1,0,0,1 during owner's message -> req_ready[owner] mirrors data_ready; data is held stable while data_valid=1 and data_ready=0; no word is lost or duplicated.
REQ-040 Pause mid-message: pause_req rises on word 1 of a 4-word message -> all 4 words are delivered, then pause_ack=1; new valids are ignored until pause_req falls, then pause_ack=0 and arbitration resumes.
REQ-041 Simultaneous pause and valid in IDLE -> PAUSED entered, no grant, req_ready stays 0.
REQ-042 Reset mid-message: rst pulse during word 2 -> all outputs 0 asynchronously; after release, ports 3 and 1 both valid -> port 1 is granted first (rr_ptr=0).
